// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame clear/render/swap
// controller for the double-buffered frame store.
module frame_sequencer #(
  parameter int         H_RES       = 320,
  parameter int         V_RES       = 240,
  parameter logic [3:0] CLEAR_COLOR = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        vga_vs,
  input  logic        gpu_done,
  input  logic [9:0]  gpu_x,
  input  logic [9:0]  gpu_y,
  input  logic [3:0]  gpu_data,
  input  logic        gpu_we,
  output logic        gpu_start,
  output logic [9:0]  fb_x,
  output logic [9:0]  fb_y,
  output logic [3:0]  fb_data,
  output logic        fb_we,
  output logic        write_buf,
  output logic [15:0] frame_count,
  output logic [7:0]  missed_frames,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
`ifdef FRAME_CLEAR_EN
    CLEAR   = 3'd1,
`endif
    START   = 3'd2,
    RENDER  = 3'd3,
    WAIT_VS = 3'd4
  } state_t;

`ifdef FRAME_CLEAR_EN
  localparam state_t     FIRST  = CLEAR;
  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [9:0] Y_LAST = 10'(V_RES - 1);
  logic [9:0] cx;
  logic [9:0] cy;
`else
  localparam state_t     FIRST  = START;
`endif

  state_t state;
  logic   vs_prev;
  logic   armed;
  logic   vs_edge;
  logic   miss_state;

  assign vs_edge    = vga_vs & ~vs_prev;
  assign miss_state = (state != IDLE)
                   && (state != WAIT_VS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      vs_prev       <= 1'b1;
      armed         <= 1'b0;
      gpu_start     <= 1'b0;
      fb_x          <= '0;
      fb_y          <= '0;
      fb_data       <= '0;
      fb_we         <= 1'b0;
      write_buf     <= 1'b0;
      frame_count   <= '0;
      missed_frames <= '0;
      busy          <= 1'b0;
`ifdef FRAME_CLEAR_EN
      cx            <= '0;
      cy            <= '0;
`endif
    end else begin
      vs_prev   <= vga_vs;
      gpu_start <= 1'b0;
      fb_we     <= 1'b0;
      if (vs_edge && miss_state
          && missed_frames != 8'hFF)
        missed_frames <= missed_frames + 8'd1;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state <= FIRST;
            busy  <= 1'b1;
          end
        end
`ifdef FRAME_CLEAR_EN
        CLEAR: begin
          fb_x    <= cx;
          fb_y    <= cy;
          fb_data <= CLEAR_COLOR;
          fb_we   <= 1'b1;
          if (cx == X_LAST) begin
            cx <= '0;
            if (cy == Y_LAST) begin
              cy    <= '0;
              state <= START;
            end else begin
              cy <= cy + 10'd1;
            end
          end else begin
            cx <= cx + 10'd1;
          end
        end
`endif
        START: begin
          gpu_start <= 1'b1;
          armed     <= 1'b0;
          state     <= RENDER;
        end
        RENDER: begin
          fb_x    <= gpu_x;
          fb_y    <= gpu_y;
          fb_data <= gpu_data;
          fb_we   <= gpu_we;
          if (!gpu_done)
            armed <= 1'b1;
          if (gpu_done && armed)
            state <= WAIT_VS;
        end
        WAIT_VS: begin
          if (vs_edge) begin
            write_buf   <= ~write_buf;
            frame_count <= frame_count + 16'd1;
            state       <= enable ? FIRST : IDLE;
            busy        <= enable;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Single-clock controller that sequences the double-buffered frame store for each frame: clear the back buffer, start the GPU, wait for render done, then swap on the next vertical-sync boundary.
- Owns the buffer-write port. It arbitrates between its internal clear engine and GPU pixel writes, and drives the write-buffer select seen by the frame buffer top.
- Reports frame progress and missed-frame statistics.

Parameters:
- H_RES, 320, pixels per line in the frame buffer (clear sweep width).
- V_RES, 240, lines per frame (clear sweep height).
- CLEAR_COLOR, 4'h0, 4-bit greyscale value written during clear.

Ports:
- clk  input  1  system clock; every register is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run frames while high; sampled only in IDLE and at swap.
- vga_vs  input  1  VGA vertical sync, synchronous to clk; a frame boundary is a rising edge.
- gpu_done  input  1  level from the GPU, high when rendering is complete.
- gpu_x  input  10  GPU pixel x.
- gpu_y  input  10  GPU pixel y.
- gpu_data  input  4  GPU pixel value.
- gpu_we  input  1  GPU pixel write strobe.
- gpu_start  output  1  one-cycle pulse that starts a render.
- fb_x  output  10  frame-buffer write x.
- fb_y  output  10  frame-buffer write y.
- fb_data  output  4  frame-buffer write data.
- fb_we  output  1  frame-buffer write enable.
- write_buf  output  1  back-buffer index being written; display reads !write_buf.
- frame_count  output  16  completed swaps; wraps 16'hFFFF to 0.
- missed_frames  output  8  frame boundaries that arrived before the render finished; saturates at 8'hFF.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - state = IDLE.
  - gpu_start, fb_we, busy, write_buf = 0.
  - fb_x, fb_y, fb_data, frame_count, missed_frames = 0.
  - Previous-vs register = 1, so no spurious edge is seen after reset.
- Reset asserted in any state returns all of the above on the next edge. Any partial clear or render is abandoned.
- vs_edge = vga_vs & !vs_prev, where vs_prev is vga_vs registered. This gives one cycle of detection latency.
- All fb_* outputs are registered, one cycle after their source.
- IDLE: fb_we = 0. If enable = 1, go to CLEAR.
- CLEAR:
  - Counters cx, cy start at 0,0. One pixel per cycle: fb_x = cx, fb_y = cy, fb_data = CLEAR_COLOR, fb_we = 1.
  - cx increments and wraps at H_RES-1. cy increments on that wrap.
  - After writing (H_RES-1, V_RES-1), go to START. The sweep takes exactly H_RES*V_RES cycles.
  - gpu_we is ignored.
- START: gpu_start = 1 for exactly one cycle, fb_we = 0, done-armed flag cleared. Go to RENDER.
- RENDER:
  - GPU pass-through: fb_x/fb_y/fb_data/fb_we follow gpu_x/gpu_y/gpu_data/gpu_we one cycle later.
  - The done-armed flag sets on the first cycle gpu_done = 0. This rejects a stale done left over from the previous frame.
  - gpu_done = 1 with the flag armed: go to WAIT_VS.
- WAIT_VS:
  - fb_we = 0; GPU writes are dropped.
  - On vs_edge: toggle write_buf and increment frame_count in the same cycle.
  - Then go to CLEAR if enable = 1, else IDLE.
- Miss accounting: a vs_edge while in CLEAR, START or RENDER increments missed_frames (saturating). No swap occurs; the displayed buffer repeats.
- Simultaneous events:
  - Armed gpu_done in the same cycle as vs_edge in RENDER: counts as a miss. Go to WAIT_VS; the swap waits for the next edge.
  - vs_edge on the exact cycle that enters WAIT_VS is not retroactively used.
- enable dropping mid-frame: the current frame completes through its swap, then the block goes to IDLE.
- busy = (state != IDLE).

Optional Feature:
- FRAME_CLEAR_EN defined: CLEAR state present as described.
- FRAME_CLEAR_EN undefined:
  - CLEAR state, its counters and CLEAR_COLOR are removed.
  - IDLE and swap go directly to START.
  - fb_* carries only GPU pass-through, gated to RENDER.

Test Plan (H_RES=4, V_RES=3):
- Reset, enable=1 → fb_we high for exactly 12 cycles covering (0,0)..(3,2) with fb_data=0. Then one gpu_start pulse, busy=1.
- In RENDER drive gpu_we=1, x=2, y=1, data=4'hA → next cycle fb_x=2, fb_y=1, fb_data=A, fb_we=1. The same write in WAIT_VS → fb_we=0.
- gpu_done held high through START → no transition until done is seen low then high. After that, the first vs rising edge toggles write_buf 0→1 and frame_count becomes 1.
- vs rising edge during RENDER → missed_frames=1, write_buf unchanged. After done, the next edge swaps. Force 300 misses → missed_frames=8'hFF.
- enable deasserted during CLEAR → frame completes, swap occurs, state returns to IDLE with busy=0. Reset asserted mid-CLEAR → all outputs at reset values the next cycle.
- Build without FRAME_CLEAR_EN → enable=1 produces gpu_start on the second cycle and fb_we is never asserted outside RENDER.
